// File: rtl/xnor_popcount_ctrl.sv
// Binary (XNOR/popcount) dot-product engine: accumulates per-beat XNOR popcounts
// over a vec_len-beat vector and reports the unsigned sum and the bipolar dot product.
module xnor_popcount_ctrl #(
    parameter int IN_WIDTH  = 32,
    parameter int LEN_WIDTH = 8,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] vec_len,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  act_data,
    input  logic [IN_WIDTH-1:0]  wgt_data,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ACC_WIDTH-1:0] res_pop,
    output logic [ACC_WIDTH-1:0] res_dot,
    output logic [1:0]           fsm_state
);

    // Handshakes: a beat transfers on a rising edge with in_valid && in_ready, a result
    // transfers on a rising edge with res_valid && res_ready; valid never depends on ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] total_bits;
    logic [ACC_WIDTH-1:0] beat_pop;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic [IN_WIDTH-1:0]  match;
    logic                 accept;
    logic                 launch;

    assign match = ~(act_data ^ wgt_data);

    always_comb begin
        beat_pop = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            beat_pop = beat_pop + ACC_WIDTH'(match[i]);
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        launch     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    launch     = 1'b1;
                    state_next = (vec_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (beat_cnt == LEN_WIDTH'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero-length vector naturally yields total_bits = 0 from the same multiply.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc        <= '0;
            beat_cnt   <= '0;
            total_bits <= '0;
        end else if (launch) begin
            acc        <= '0;
            beat_cnt   <= vec_len;
            total_bits <= ACC_WIDTH'(vec_len) * ACC_WIDTH'(IN_WIDTH);
        end else if (accept) begin
            acc      <= acc + beat_pop;
            beat_cnt <= beat_cnt - LEN_WIDTH'(1);
        end
    end

    assign busy      = (state != IDLE);
    assign in_ready  = (state == RUN);
    assign res_valid = (state == DONE);
    assign res_pop   = res_valid ? acc : '0;
    assign res_dot   = res_valid ? (acc + acc - total_bits) : '0;
    assign fsm_state = state;

endmodule

// File: doc/xnor_popcount_ctrl.md
XNOR_POPCOUNT_CTRL -- requirements
Module: xnor_popcount_ctrl

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 32, giving the bits per activation/weight beat.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 8, giving the width of the beat-count field.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 16, giving the width of the popcount accumulator and the signed dot-product output.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 start  input  1  one-cycle request to begin a vector operation.
REQ-007 vec_len  input  LEN_WIDTH  number of beats in the vector, sampled when start is accepted.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 in_valid  input  1  activation/weight beat valid.
REQ-010 in_ready  output  1  block accepts a beat; high only in RUN.
REQ-011 act_data  input  IN_WIDTH  binary activation word, bit 1 = +1, bit 0 = -1.
REQ-012 wgt_data  input  IN_WIDTH  binary weight word, same encoding.
REQ-013 res_valid  output  1  result available.
REQ-014 res_ready  input  1  consumer accepts result.
REQ-015 res_pop  output  ACC_WIDTH  unsigned sum of XNOR popcounts over the vector.
REQ-016 res_dot  output  ACC_WIDTH  signed bipolar dot product, two's complement.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-018 In IDLE, start=1 with vec_len!=0 SHALL clear the accumulator, load the beat counter with vec_len, latch total_bits = vec_len*IN_WIDTH, and move to RUN on the next edge.
REQ-019 In IDLE, start=1 with vec_len==0 SHALL clear the accumulator, set total_bits=0, and move directly to DONE, giving res_pop=0 and res_dot=0.
REQ-020 start SHALL be ignored in RUN and DONE; there is no queuing.
REQ-021 A beat SHALL be accepted on any edge where in_valid && in_ready; in_valid without in_ready SHALL have no effect.
REQ-022 On each accepted beat, the accumulator SHALL add popcount(~(act_data ^ wgt_data)), a value from 0 to IN_WIDTH, and the beat counter SHALL decrement by 1.
REQ-023 When the beat counter is 1 and a beat is accepted, the FSM SHALL move to DONE on that edge, and res_valid SHALL be high in the next cycle (one-cycle latency from the last beat).
REQ-024 in_valid low in RUN SHALL hold all state; bubbles of any length SHALL be allowed.
REQ-025 In DONE, res_valid=1, res_pop=accumulator and res_dot=2*accumulator - total_bits; both SHALL be stable until the handshake.
REQ-026 A DONE edge with res_ready=1 SHALL return the FSM to IDLE, with res_valid low in the next cycle; res_ready=0 SHALL hold DONE indefinitely.
REQ-027 A start pulse in the same cycle as the DONE->IDLE handshake SHALL be ignored; start is accepted only when the FSM is already in IDLE.
REQ-028 All arithmetic SHALL be performed at ACC_WIDTH and wrap modulo 2^ACC_WIDTH.
REQ-029 With default parameters, the maximum value 255*32=8160 fits without wrap.
REQ-030 The popcount SHALL be purely combinational on the accepted beat; there SHALL be no other internal pipeline stage.
REQ-031 Outputs SHALL be driven only from registers or state decode, with no combinational path from in_valid or res_ready to any output.

Reset
REQ-032 When rst_n=0 at an edge, the FSM SHALL go to IDLE and accumulator, beat counter and total_bits SHALL clear to 0.
REQ-033 During and after reset: busy=0, in_ready=0, res_valid=0, res_pop=0, res_dot=0.
REQ-034 Reset asserted mid-RUN or in DONE SHALL abort the operation and discard the result; no res_valid pulse SHALL follow.
REQ-035 Reset SHALL take priority over start, beat and result handshakes in the same cycle.

Verification
REQ-036 vec_len=1, act=0xFFFFFFFF, wgt=0xFFFFFFFF, res_ready=1 -> res_valid one cycle after the beat, res_pop=32, res_dot=32, then IDLE.
REQ-037 vec_len=2, beats (0xFFFF0000,0xFFFFFFFF) then (0x0,0xFFFFFFFF) -> res_pop=16, res_dot=-32 (0xFFE0).
REQ-038 vec_len=3, in_valid toggling with 2-cycle bubbles, each beat matching 8 bits -> res_pop=24, res_dot=-48; no extra beats consumed; in_ready low after the third beat.
REQ-039 vec_len=0 start -> DONE next cycle, res_pop=0, res_dot=0; start pulses during RUN/DONE are ignored.
REQ-040 res_ready held 0 for 5 cycles in DONE -> res_valid and results held stable; handshake on cycle 6 -> IDLE.
REQ-041 rst_n=0 after 2 of 4 beats -> all outputs 0 next cycle; a new start with vec_len=1 then gives a correct fresh result.
